// File: rtl/program_loader.sv
// program_loader
//   Captures instruction words streamed by the assembler during its
//   instruction-mapping pass into a word-addressed RAM. Once the assembler
//   reports SUCCESS, it serves processor instruction fetches with a fixed
//   2-cycle latency.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   defined   -> rotate-xor running checksum of every stored word on checksum_out
//   undefined -> checksum_out tied to 0
//
// Ports
//   clk_in, rst_n_in       pixel clock, async active-low reset
//   assembler_state_in     assembler phase (constants_pkg::assembler_state_t)
//   instr_valid_in/instr_in  one-cycle instruction write strobe + word
//   fetch_req_in/fetch_addr_in  fetch request, byte PC
//   fetch_valid_out/fetch_data_out/fetch_fault_out  response, 2 cycles after request
//   program_ready_out      program loaded and fetchable
//   instr_count_out        number of stored words (saturates at DEPTH)
//   overflow_out           sticky: write attempted while full
//   checksum_out           running program checksum

package constants_pkg;
  typedef enum logic [2:0] {
    IDLE                = 3'd0,
    PC_MAPPING          = 3'd1,
    INSTRUCTION_MAPPING = 3'd2,
    SUCCESS             = 3'd3,
    ERROR               = 3'd4
  } assembler_state_t;
endpackage

module program_loader
  import constants_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  assembler_state_t assembler_state_in,
  input  logic             instr_valid_in,
  input  logic [31:0]      instr_in,
  input  logic             fetch_req_in,
  input  logic [31:0]      fetch_addr_in,
  output logic             fetch_valid_out,
  output logic [31:0]      fetch_data_out,
  output logic             fetch_fault_out,
  output logic             program_ready_out,
  output logic [AW:0]      instr_count_out,
  output logic             overflow_out,
  output logic [31:0]      checksum_out
);

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_READY, ST_FAULT} state_t;

  state_t           state, state_nxt;
  assembler_state_t asm_prev;
  logic [AW:0]      wr_ptr;
  logic [31:0]      mem [DEPTH];

  logic rearm, wr_en, ovf_hit, clr;

  // Re-arm fires only on the transition into INSTRUCTION_MAPPING, so a
  // long mapping pass does not keep clearing the RAM pointer.
  assign rearm   = (assembler_state_in == INSTRUCTION_MAPPING) &&
                   (asm_prev != INSTRUCTION_MAPPING);
  assign wr_en   = (state == ST_LOADING) && instr_valid_in && (wr_ptr != FULL);
  assign ovf_hit = (state == ST_LOADING) && instr_valid_in && (wr_ptr == FULL);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_EMPTY;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    unique case (state)
      ST_EMPTY, ST_READY, ST_FAULT: begin
        if (rearm) begin
          state_nxt = ST_LOADING;
          clr       = 1'b1;
        end
      end
      ST_LOADING: begin
        // Overflow wins over a simultaneous SUCCESS: the program is incomplete.
        if (ovf_hit)                                state_nxt = ST_FAULT;
        else if (assembler_state_in == ERROR)       state_nxt = ST_FAULT;
        else if (assembler_state_in == SUCCESS)     state_nxt = ST_READY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // program_ready_out decodes the state register, so it drops with reset.
  assign program_ready_out = (state == ST_READY);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      asm_prev     <= IDLE;
      wr_ptr       <= '0;
      overflow_out <= 1'b0;
    end else begin
      asm_prev <= assembler_state_in;
      if (clr) begin
        wr_ptr       <= '0;
        overflow_out <= 1'b0;
      end else begin
        if (wr_en)   wr_ptr       <= wr_ptr + 1'b1;
        if (ovf_hit) overflow_out <= 1'b1;
      end
    end
  end

  assign instr_count_out = wr_ptr;

  // RAM contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= instr_in;
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)  checksum <= '0;
    else if (clr)   checksum <= '0;
    else if (wr_en) checksum <= {checksum[30:0], checksum[31]} ^ instr_in;
  end
  assign checksum_out = checksum;
`else
  assign checksum_out = 32'h0;
`endif

  // ---------------- fetch pipeline ----------------
  // Fault is decided at request time against the current state/count; the
  // in-flight response is unaffected by anything that happens afterwards.
  logic [AW-1:0] f_idx;
  logic          f_fault;
  logic [1:0]    vld_pipe;  // [0]: RAM read stage, [1]: response stage
  logic          fault_q;
  logic [31:0]   rd_q;

  assign f_idx   = fetch_addr_in[AW+1:2];
  assign f_fault = (state != ST_READY) ||
                   (fetch_addr_in[1:0] != 2'b00) ||
                   (fetch_addr_in[31:AW+2] != '0) ||
                   ({1'b0, f_idx} >= wr_ptr);

  always_ff @(posedge clk_in) begin
    rd_q <= mem[f_idx];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe        <= '0;
      fault_q         <= 1'b0;
      fetch_data_out  <= '0;
      fetch_fault_out <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], fetch_req_in};
      fault_q  <= f_fault;
      if (vld_pipe[0]) begin
        fetch_data_out  <= fault_q ? NOP : rd_q;
        fetch_fault_out <= fault_q;
      end else begin
        fetch_data_out  <= '0;
        fetch_fault_out <= 1'b0;
      end
    end
  end

  assign fetch_valid_out = vld_pipe[1];

endmodule
